maple_tx_sequencer: RTL and testbench

//  Frame transmitter and pin-ownership arbiter for the Maple bus. Pulls bytes off a

---
 rtl/maple_pkg.sv | 27 ++
 rtl/maple_pin_mux.sv | 19 +
 rtl/maple_tx_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_maple_tx_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared types and sizing for the Maple bus transmit path.
package maple_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned BIT_W            = 3;
  localparam int unsigned STEP_W           = 8;
  localparam int unsigned DEF_START_PULSES = 4;
  localparam int unsigned DEF_END_PULSES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_END   = 3'd4
  } state_e;

  typedef struct packed {
    logic p1;
    logic p5;
    logic oe;
  } pins_t;

  // Sequencer's own drive while not framing: both lines high, driver released.
  localparam pins_t PINS_IDLE = '{p1: 1'b1, p5: 1'b1, oe: 1'b0};

endpackage

// File: rtl/maple_pin_mux.sv
// Pin ownership select between manual register control and the frame sequencer.
module maple_pin_mux
  import maple_pkg::*;
(
  input  logic  busy_i,
  input  pins_t man_i,
  input  pins_t seq_i,
  output pins_t pins_c
);

  // Sequencer owns the pins for the whole frame; otherwise manual levels pass through.
  always_comb begin
    pins_c = man_i;
    if (busy_i) begin
      pins_c = seq_i;
    end
  end

endmodule

// File: rtl/maple_tx_sequencer.sv
// Maple bus frame transmitter: start pattern, MSB-first data bits, end pattern,
// one pin step per divider tick, with manual pin passthrough while idle.
module maple_tx_sequencer
  import maple_pkg::*;
#(
  parameter int unsigned START_PULSES = DEF_START_PULSES,
  parameter int unsigned END_PULSES   = DEF_END_PULSES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              man_p1,
  input  logic              man_p5,
  input  logic              man_oe,
  output logic              out_p1,
  output logic              out_p5,
  output logic              oe,
  output logic              busy,
  output logic              underrun,
  input  logic              clr_underrun
);

  // Step indices that end each pattern phase.
  localparam logic [STEP_W-1:0] START_FIN = STEP_W'(2 * START_PULSES + 2);
  localparam logic [STEP_W-1:0] END_P5    = STEP_W'(2 * END_PULSES + 1);
  localparam logic [STEP_W-1:0] END_FIN   = STEP_W'(2 * END_PULSES + 2);
  localparam logic [STEP_W-1:0] STEP_A    = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_B    = STEP_W'(1);
  localparam logic [BIT_W-1:0]  BIT_FIN   = BIT_W'(7);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  pins_t             seq_q, seq_d;
  logic              underrun_q, underrun_d;

  pins_t man_pins;
  pins_t mux_pins;

  // Frame state, counters, shifter and sequencer pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      seq_q      <= PINS_IDLE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      seq_q      <= seq_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state and pin-step decode; pattern steps advance only on tick.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    last_d     = last_q;
    seq_d      = seq_q;
    // A set in the same clk overrides the clear below.
    underrun_d = underrun_q & ~clr_underrun;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          last_d  = in_last;
          step_d  = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          step_d = step_q + STEP_W'(1);
          if (step_q == STEP_A) begin
            seq_d = '{p1: 1'b1, p5: 1'b1, oe: 1'b1};
          end else if (step_q == STEP_B) begin
            seq_d.p1 = 1'b0;
          end else if (step_q == START_FIN) begin
            seq_d.p1 = 1'b1;
            step_d   = '0;
            bit_d    = '0;
            state_d  = ST_DATA;
          end else begin
            // Step 2 drives p5 low, then it alternates.
            seq_d.p5 = step_q[0];
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          step_d = step_q + STEP_W'(1);
          // Even-numbered bits clock on p1 with data on p5; odd ones swap lines.
          if (step_q == STEP_A) begin
            if (bit_q[0]) begin
              seq_d.p1 = shift_q[BYTE_W-1];
              seq_d.p5 = 1'b1;
            end else begin
              seq_d.p5 = shift_q[BYTE_W-1];
              seq_d.p1 = 1'b1;
            end
          end else if (step_q == STEP_B) begin
            if (bit_q[0]) begin
              seq_d.p5 = 1'b0;
            end else begin
              seq_d.p1 = 1'b0;
            end
          end else begin
            if (bit_q[0]) begin
              seq_d.p5 = 1'b1;
            end else begin
              seq_d.p1 = 1'b1;
            end
            step_d  = '0;
            shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_FIN) begin
              state_d = last_q ? ST_END : ST_LOAD;
            end
          end
        end
      end

      ST_LOAD: begin
        step_d = '0;
        bit_d  = '0;
        if (in_valid) begin
          shift_d = in_data;
          last_d  = in_last;
          state_d = ST_DATA;
        end else begin
          // Stream ran dry mid-frame: close the frame with the end pattern.
          underrun_d = 1'b1;
          state_d    = ST_END;
        end
      end

      ST_END: begin
        if (tick) begin
          step_d = step_q + STEP_W'(1);
          if (step_q == STEP_A) begin
            seq_d.p5 = 1'b0;
            seq_d.p1 = 1'b1;
          end else if (step_q == END_P5) begin
            seq_d.p5 = 1'b1;
          end else if (step_q == END_FIN) begin
            seq_d.oe = 1'b0;
            step_d   = '0;
            state_d  = ST_IDLE;
          end else begin
            // Step 1 drives p1 low, then it alternates.
            seq_d.p1 = ~step_q[0];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign underrun = underrun_q;

  assign man_pins = '{p1: man_p1, p5: man_p5, oe: man_oe};

  maple_pin_mux u_pin_mux (
    .busy_i (busy),
    .man_i  (man_pins),
    .seq_i  (seq_q),
    .pins_c (mux_pins)
  );

  assign out_p1 = mux_pins.p1;
  assign out_p5 = mux_pins.p5;
  assign oe     = mux_pins.oe;

endmodule

// File: tb/tb_maple_tx_sequencer.sv
// Directed + randomized frame bench for maple_tx_sequencer against a tick-level pin model.
module tb_maple_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       man_p1, man_p5, man_oe;
  logic       clr_underrun;
  logic       sel_b;

  logic tick_a, tick_b, valid_a, valid_b;
  logic ready_a, ready_b, p1_a, p1_b, p5_a, p5_b, oe_a, oe_b;
  logic busy_a, busy_b, under_a, under_b;
  logic obs_ready, obs_p1, obs_p5, obs_oe, obs_busy, obs_under;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int hs_cnt;

  logic [8:0] src_q[$];    // {last,data} offered on the stream
  logic [8:0] frame_q[$];  // bytes the frame is expected to carry
  logic [4:0] exp_q[$];    // {busy,ready,p1,p5,oe} after each consumed tick

  always #5 clk = ~clk;

  assign tick_a  = tick & ~sel_b;
  assign tick_b  = tick & sel_b;
  assign valid_a = in_valid & ~sel_b;
  assign valid_b = in_valid & sel_b;

  assign obs_ready = sel_b ? ready_b : ready_a;
  assign obs_p1    = sel_b ? p1_b    : p1_a;
  assign obs_p5    = sel_b ? p5_b    : p5_a;
  assign obs_oe    = sel_b ? oe_b    : oe_a;
  assign obs_busy  = sel_b ? busy_b  : busy_a;
  assign obs_under = sel_b ? under_b : under_a;

  maple_tx_sequencer dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .in_data(in_data), .in_last(in_last),
    .in_valid(valid_a), .in_ready(ready_a), .man_p1(man_p1), .man_p5(man_p5),
    .man_oe(man_oe), .out_p1(p1_a), .out_p5(p5_a), .oe(oe_a), .busy(busy_a),
    .underrun(under_a), .clr_underrun(clr_underrun)
  );

  maple_tx_sequencer #(.START_PULSES(2), .END_PULSES(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .in_data(in_data), .in_last(in_last),
    .in_valid(valid_b), .in_ready(ready_b), .man_p1(man_p1), .man_p5(man_p5),
    .man_oe(man_oe), .out_p1(p1_b), .out_p5(p5_b), .oe(oe_b), .busy(busy_b),
    .underrun(under_b), .clr_underrun(clr_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      {in_last, in_data} = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  // One clock; handshakes are judged on the values present at the edge.
  task automatic clk_step();
    bit hs;
    hs = in_valid && obs_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      void'(src_q.pop_front());
      hs_cnt++;
    end
    drive_src();
  endtask

  task automatic push(input bit rdy, input bit p1, input bit p5);
    exp_q.push_back({1'b1, rdy, p1, p5, 1'b1});
  endtask

  // Expected pin levels after every tick of a frame, from the line protocol rules.
  task automatic build_model(input int s, input int e);
    bit p1, p5, d, ld;
    exp_q.delete();
    p1 = 1; p5 = 1; push(0, p1, p5);
    p1 = 0; push(0, p1, p5);
    for (int k = 0; k < 2 * s; k++) begin
      p5 = (k % 2 == 1);
      push(0, p1, p5);
    end
    p1 = 1; push(0, p1, p5);
    foreach (frame_q[f]) begin
      for (int i = 7; i >= 0; i--) begin
        d  = frame_q[f][i];
        ld = (i == 0) && !frame_q[f][8];
        if ((7 - i) % 2 == 0) begin
          p5 = d; p1 = 1; push(0, p1, p5);
          p1 = 0; push(0, p1, p5);
          p1 = 1; push(ld, p1, p5);
        end else begin
          p1 = d; p5 = 1; push(0, p1, p5);
          p5 = 0; push(0, p1, p5);
          p5 = 1; push(ld, p1, p5);
        end
      end
    end
    p5 = 0; p1 = 1; push(0, p1, p5);
    for (int k = 0; k < 2 * e; k++) begin
      p1 = (k % 2 == 1);
      push(0, p1, p5);
    end
    p5 = 1; push(0, p1, p5);
    exp_q.push_back(5'b01000);  // back to idle: pins follow manual levels
  endtask

  // Runs one frame of frame_q; abort_at>0 resets the DUT after that many ticks.
  task automatic run_frame(input string tag, input int s, input int e, input int gap,
                           input bit exp_under, input bit clr_at_load, input int abort_at);
    int         gp;
    logic [4:0] want;
    build_model(s, e);
    src_q  = frame_q;
    hs_cnt = 0;
    drive_src();
    check({tag, "_idle_busy"}, obs_busy, 0);
    check({tag, "_idle_ready"}, obs_ready, 1);
    clk_step();
    check({tag, "_accept"}, {obs_busy, obs_p1, obs_p5, obs_oe}, 4'b1110);
    foreach (exp_q[i]) begin
      tick = 1'b1;
      clk_step();
      tick = 1'b0;
      want = exp_q[i];
      if (i == exp_q.size() - 1) want[2:0] = {man_p1, man_p5, man_oe};
      check($sformatf("%s_tick%0d", tag, i),
            {obs_busy, obs_ready, obs_p1, obs_p5, obs_oe}, want);
      if (abort_at > 0 && i == abort_at - 1) begin
        src_q.delete();
        drive_src();
        {man_p1, man_p5, man_oe} = 3'b011;
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        check({tag, "_rst_state"}, {obs_busy, obs_ready, obs_under}, 3'b010);
        check({tag, "_rst_pins"}, {obs_p1, obs_p5, obs_oe}, 3'b011);
        return;
      end
      gp = (gap > 0) ? gap : int'($urandom_range(1, 4));
      for (int g = 0; g < gp; g++) begin
        clr_underrun = clr_at_load && (g == 0) && exp_q[i][4] && exp_q[i][3];
        {man_p1, man_p5, man_oe} = 3'($urandom);
        clk_step();
      end
      clr_underrun = 1'b0;
    end
    check({tag, "_len_busy"}, obs_busy, 0);
    check({tag, "_handshakes"}, hs_cnt, frame_q.size());
    check({tag, "_underrun"}, obs_under, exp_under);
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int k = 0; k < n; k++) frame_q.push_back({(k == n - 1), 8'($urandom)});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    clr_underrun = 1'b0; sel_b = 1'b0;
    {man_p1, man_p5, man_oe} = 3'b110;
    repeat (3) clk_step();
    rst = 1'b0;
    clk_step();

    // Reset state on both instances.
    check("reset_a", {obs_busy, obs_ready, obs_under, obs_p1, obs_p5, obs_oe}, 6'b010110);
    sel_b = 1'b1;
    #1;
    check("reset_b", {obs_busy, obs_ready, obs_under, obs_p1, obs_p5, obs_oe}, 6'b010110);
    sel_b = 1'b0;

    // Single byte 0xA5, tick every 6 clk: 42 ticks.
    frame_q = '{9'h1A5};
    run_frame("a5", 4, 2, 5, 0, 0, 0);
    check("a5_model_len", exp_q.size(), 42);

    // Three back-to-back bytes.
    frame_q = '{9'h001, 9'h0FF, 9'h180};
    run_frame("three", 4, 2, 2, 0, 0, 0);

    // Second byte withheld; clear collides with the set at LOAD, set must win.
    frame_q = '{9'h03C};
    run_frame("under", 4, 2, -1, 1, 1, 0);
    clr_underrun = 1'b1;
    clk_step();
    clr_underrun = 1'b0;
    check("clr_underrun", obs_under, 0);

    // Reset mid-DATA, then a clean frame.
    frame_q = '{9'h05A, 9'h1C3};
    run_frame("abort", 4, 2, 3, 0, 0, 15);
    rand_frame(1);
    run_frame("post_abort", 4, 2, -1, 0, 0, 0);

    // Idle passthrough; ticks while idle consume nothing.
    {man_p1, man_p5, man_oe} = 3'b011;
    clk_step();
    check("pass_pins", {obs_p1, obs_p5, obs_oe}, 3'b011);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      clk_step();
      tick = 1'b0;
      clk_step();
    end
    check("idle_tick", {obs_busy, obs_ready}, 2'b01);
    {man_p1, man_p5, man_oe} = 3'b100;
    clk_step();
    check("pass_pins2", {obs_p1, obs_p5, obs_oe}, 3'b100);

    // Randomized frames on the default instance.
    for (int r = 0; r < 3; r++) begin
      rand_frame(int'($urandom_range(1, 3)));
      run_frame($sformatf("rnd%0d", r), 4, 2, -1, 0, 0, 0);
    end

    // Shorter start/end patterns.
    sel_b = 1'b1;
    #1;
    frame_q = '{9'h1A5};
    run_frame("short", 2, 1, 2, 0, 0, 0);
    check("short_model_len", exp_q.size(), 7 + 24 + 4 + 1);
    for (int r = 0; r < 2; r++) begin
      rand_frame(int'($urandom_range(1, 3)));
      run_frame($sformatf("srnd%0d", r), 2, 1, -1, 0, 0, 0);
    end
    frame_q = '{9'h0E7};
    run_frame("sunder", 2, 1, -1, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
